xc_malu_div_seq: RTL and testbench

XC_MALU_DIV_SEQ -- requirements
Module: xc_malu_div_seq

---
 rtl/xc_malu_pkg.sv | 28 ++
 rtl/xc_malu_div_fixup.sv | 34 +++
 rtl/xc_malu_div_seq.sv | 137 +++++++++++++
 tb/tb_xc_malu_div_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xc_malu_pkg.sv
// Shared definitions for the xc_malu multi-cycle arithmetic blocks:
// divider FSM encoding, operation-select bit positions and small decode helpers.
package xc_malu_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam int OP_W    = 4;
    localparam int OP_DIV  = 0;
    localparam int OP_DIVU = 1;
    localparam int OP_REM  = 2;
    localparam int OP_REMU = 3;

    // 32 restoring-division steps; count parks here until the step unit reports done
    localparam logic [5:0] DIV_COUNT_MAX = 6'd32;

    function automatic logic op_is_signed(input logic [OP_W-1:0] op);
        return op[OP_DIV] | op[OP_REM];
    endfunction

    function automatic logic op_is_quot(input logic [OP_W-1:0] op);
        return op[OP_DIV] | op[OP_DIVU];
    endfunction

endpackage

// File: rtl/xc_malu_div_fixup.sv
// Turns the step unit's unsigned quotient/remainder magnitudes into the final
// architectural result, including the divide-by-zero convention.
module xc_malu_div_fixup
    import xc_malu_pkg::*;
(
    input  logic [31:0]     rs1,
    input  logic [31:0]     rs2,
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     arg_0,
    input  logic [31:0]     arg_1,
    output logic [31:0]     result
);

    logic is_signed;
    logic is_quot;
    logic div_zero;

    assign is_signed = op_is_signed(op);
    assign is_quot   = op_is_quot(op);
    assign div_zero  = (rs2 == 32'd0);

    // Zero divisor bypasses the magnitudes entirely, so the fast path needs no step data
    always_comb begin
        result = arg_0;
        if (div_zero) begin
            result = is_quot ? 32'hFFFF_FFFF : rs1;
        end else if (is_quot) begin
            result = (is_signed && (rs1[31] != rs2[31])) ? (32'd0 - arg_1) : arg_1;
        end else begin
            result = (is_signed && rs1[31]) ? (32'd0 - arg_0) : arg_0;
        end
    end

endmodule

// File: rtl/xc_malu_div_seq.sv
// Sequencer for the iterative divider: captures operands, drives an external
// step unit until it reports completion, then presents the sign-corrected result.
module xc_malu_div_seq
    import xc_malu_pkg::*;
#(
    parameter int ZERO_FAST = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic        flush,
    input  logic        op_div,
    input  logic        op_divu,
    input  logic        op_rem,
    input  logic        op_remu,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        ready,
    output logic [31:0] result,
    output logic        step_valid,
    output logic        step_op_signed,
    output logic        step_flush,
    output logic [31:0] step_rs1,
    output logic [31:0] step_rs2,
    output logic [5:0]  count,
    output logic [63:0] acc,
    output logic [31:0] arg_0,
    output logic [31:0] arg_1,
    input  logic [63:0] n_acc,
    input  logic [31:0] n_arg_0,
    input  logic [31:0] n_arg_1,
    input  logic        step_ready
);

    div_state_t      state;
    div_state_t      next_state;
    logic [OP_W-1:0] op_in;
    logic [OP_W-1:0] op_q;
    logic [31:0]     rs1_q;
    logic [31:0]     rs2_q;
    logic            accept;
    logic            zero_hit;
    logic            result_load;
    logic [31:0]     fix_rs1;
    logic [31:0]     fix_rs2;
    logic [OP_W-1:0] fix_op;
    logic [31:0]     fix_result;

    always_comb begin
        op_in          = '0;
        op_in[OP_DIV]  = op_div;
        op_in[OP_DIVU] = op_divu;
        op_in[OP_REM]  = op_rem;
        op_in[OP_REMU] = op_remu;
    end

    assign accept      = (state == DIV_IDLE) && valid && !flush;
    assign zero_hit    = accept && (ZERO_FAST != 0) && (rs2 == 32'd0);
    assign result_load = zero_hit || ((state == DIV_RUN) && step_ready && !flush);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DIV_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: if (valid) next_state = zero_hit ? DIV_DONE : DIV_RUN;
                DIV_RUN:  if (step_ready) next_state = DIV_DONE;
                DIV_DONE: if (!valid) next_state = DIV_IDLE;
                default:  next_state = DIV_IDLE;
            endcase
        end
    end

    always_comb begin
        ready      = (state == DIV_DONE);
        step_valid = (state == DIV_RUN);
    end

    assign step_flush     = flush;
    assign step_op_signed = op_is_signed(op_q);
    assign step_rs1       = rs1_q;
    assign step_rs2       = rs2_q;

    // In IDLE the fast zero path must fix up the incoming operands before they are registered
    assign fix_rs1 = (state == DIV_IDLE) ? rs1   : rs1_q;
    assign fix_rs2 = (state == DIV_IDLE) ? rs2   : rs2_q;
    assign fix_op  = (state == DIV_IDLE) ? op_in : op_q;

    xc_malu_div_fixup u_fixup (
        .rs1    (fix_rs1),
        .rs2    (fix_rs2),
        .op     (fix_op),
        .arg_0  (arg_0),
        .arg_1  (arg_1),
        .result (fix_result)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rs1_q  <= '0;
            rs2_q  <= '0;
            op_q   <= '0;
            count  <= '0;
            acc    <= '0;
            arg_0  <= '0;
            arg_1  <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                rs1_q <= rs1;
                rs2_q <= rs2;
                op_q  <= op_in;
            end
            if (state == DIV_RUN) begin
                acc   <= n_acc;
                arg_0 <= n_arg_0;
                arg_1 <= n_arg_1;
                count <= (count == DIV_COUNT_MAX) ? count : count + 6'd1;
            end else if (accept) begin
                count <= '0;
            end
            if (result_load) begin
                result <= fix_result;
            end
        end
    end

endmodule

// File: tb/tb_xc_malu_div_seq.sv
// Scoreboard bench for xc_malu_div_seq with a behavioural restoring-division step unit.
module tb_xc_malu_div_seq;
    import xc_malu_pkg::*;

    localparam logic [3:0] OPB_DIV  = 4'b0001 << OP_DIV;
    localparam logic [3:0] OPB_DIVU = 4'b0001 << OP_DIVU;
    localparam logic [3:0] OPB_REM  = 4'b0001 << OP_REM;
    localparam logic [3:0] OPB_REMU = 4'b0001 << OP_REMU;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid;
    logic        flush;
    logic        op_div, op_divu, op_rem, op_remu;
    logic [31:0] rs1, rs2;
    logic        ready;
    logic [31:0] result;
    logic        step_valid, step_op_signed, step_flush;
    logic [31:0] step_rs1, step_rs2;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [31:0] arg_0, arg_1;
    logic [63:0] n_acc;
    logic [31:0] n_arg_0, n_arg_1;
    logic        step_ready;

    typedef struct {
        string       name;
        logic [31:0] exp;
        int          issue;
        int          lat;
        bit          zero;
    } exp_t;

    exp_t        sb_q[$];
    int          n_compared = 0;
    int          n_failed   = 0;
    int          cyc        = 0;
    bit          sv_seen    = 0;
    logic        ready_prev = 0;
    logic        sr_prev    = 0;
    logic [31:0] cur_exp    = '0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    xc_malu_div_seq #(.ZERO_FAST(1)) dut (
        .clock          (clock),
        .reset          (reset),
        .valid          (valid),
        .flush          (flush),
        .op_div         (op_div),
        .op_divu        (op_divu),
        .op_rem         (op_rem),
        .op_remu        (op_remu),
        .rs1            (rs1),
        .rs2            (rs2),
        .ready          (ready),
        .result         (result),
        .step_valid     (step_valid),
        .step_op_signed (step_op_signed),
        .step_flush     (step_flush),
        .step_rs1       (step_rs1),
        .step_rs2       (step_rs2),
        .count          (count),
        .acc            (acc),
        .arg_0          (arg_0),
        .arg_1          (arg_1),
        .n_acc          (n_acc),
        .n_arg_0        (n_arg_0),
        .n_arg_1        (n_arg_1),
        .step_ready     (step_ready)
    );

    // Companion step unit: one quotient bit per cycle, initialised from the operands at count 0
    logic [31:0] m_a, m_b, m_rem, m_q;
    logic [63:0] m_div;
    always_comb begin
        m_a   = (step_op_signed && step_rs1[31]) ? (32'd0 - step_rs1) : step_rs1;
        m_b   = (step_op_signed && step_rs2[31]) ? (32'd0 - step_rs2) : step_rs2;
        m_div = acc;
        m_rem = arg_0;
        m_q   = arg_1;
        if (count == 6'd0) begin
            m_div = {1'b0, m_b, 31'd0};
            m_rem = m_a;
            m_q   = 32'd0;
        end
        n_acc   = m_div;
        n_arg_0 = m_rem;
        n_arg_1 = m_q;
        if (count < 6'd32) begin
            n_acc = m_div >> 1;
            if (m_div <= {32'd0, m_rem}) begin
                n_arg_0 = m_rem - m_div[31:0];
                n_arg_1 = {m_q[30:0], 1'b1};
            end else begin
                n_arg_1 = {m_q[30:0], 1'b0};
            end
        end
        step_ready = step_valid && (count == 6'd32);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_compared++;
        if (act !== req) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic driveOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        valid   = 1'b1;
        op_div  = op[OP_DIV];
        op_divu = op[OP_DIVU];
        op_rem  = op[OP_REM];
        op_remu = op[OP_REMU];
        rs1     = a;
        rs2     = b;
    endtask

    task automatic clearOp();
        valid   = 1'b0;
        op_div  = 1'b0;
        op_divu = 1'b0;
        op_rem  = 1'b0;
        op_remu = 1'b0;
    endtask

    task automatic applyStimulus(input string name, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp, input int hold);
        exp_t e;
        bit   got;
        driveOp(op, a, b);
        e.name  = name;
        e.exp   = exp;
        e.issue = cyc;
        e.zero  = (b == 32'd0);
        e.lat   = e.zero ? 1 : 34;
        sb_q.push_back(e);
        sv_seen = 0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            if (ready) got = 1;
        end
        if (!got) checkOutput({"timeout_", name}, {63'd0, ready}, 64'd1);
        repeat (hold) @(negedge clock);
        clearOp();
        @(negedge clock);
        if (hold > 0) checkOutput({"idle_after_drop_", name}, {63'd0, ready}, 64'd0);
    endtask

    // Monitor: pops an expectation on each rising ready and checks hold-stability afterwards
    always @(negedge clock) begin
        if (!reset) begin
            if (step_valid) sv_seen = 1;
            if (ready && !ready_prev) begin
                if (sb_q.size() == 0) begin
                    checkOutput("ready_without_request", {63'd0, ready}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    cur_exp = e.exp;
                    checkOutput({"result_", e.name}, {32'd0, result}, {32'd0, e.exp});
                    checkOutput({"latency_", e.name}, 64'(cyc - e.issue), 64'(e.lat));
                    if (e.zero) checkOutput({"no_step_valid_", e.name}, {63'd0, sv_seen}, 64'd0);
                    else        checkOutput({"step_ready_prev_", e.name}, {63'd0, sr_prev}, 64'd1);
                end
            end else if (ready && ready_prev) begin
                checkOutput("result_stable", {32'd0, result}, {32'd0, cur_exp});
            end
            ready_prev = ready;
            sr_prev    = step_ready;
        end else begin
            ready_prev = 1'b0;
            sr_prev    = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1;
        flush = 1'b0;
        rs1   = '0;
        rs2   = '0;
        clearOp();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("reset_ready", {63'd0, ready}, 64'd0);
        checkOutput("reset_step_valid", {63'd0, step_valid}, 64'd0);
        checkOutput("reset_count", {58'd0, count}, 64'd0);
        checkOutput("reset_acc", acc, 64'd0);
        checkOutput("reset_arg_0", {32'd0, arg_0}, 64'd0);
        checkOutput("reset_arg_1", {32'd0, arg_1}, 64'd0);
        checkOutput("reset_result", {32'd0, result}, 64'd0);
        checkOutput("reset_step_rs1", {32'd0, step_rs1}, 64'd0);

        applyStimulus("divu_100_7",   OPB_DIVU, 32'd100,       32'd7,         32'd14,        0);
        applyStimulus("remu_100_7",   OPB_REMU, 32'd100,       32'd7,         32'd2,         0);
        applyStimulus("rem_m7_2",     OPB_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
        applyStimulus("div_m7_2",     OPB_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
        applyStimulus("div_7_m2",     OPB_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
        applyStimulus("rem_7_m2",     OPB_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         0);
        applyStimulus("div_ovf",      OPB_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        applyStimulus("rem_ovf",      OPB_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);
        applyStimulus("divu_5_0",     OPB_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
        applyStimulus("remu_5_0",     OPB_REMU, 32'd5,         32'd0,         32'd5,         0);
        applyStimulus("div_m7_0",     OPB_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 0);
        applyStimulus("rem_m7_0",     OPB_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 0);
        applyStimulus("divu_max_1",   OPB_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 0);

        // Flush part-way through an iteration, then a fresh request
        driveOp(OPB_DIVU, 32'd100, 32'd7);
        n = 0;
        while (count != 6'd10 && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("flush_reach_count10", {58'd0, count}, 64'd10);
        clearOp();
        flush = 1'b1;
        #1;
        checkOutput("step_flush_follows", {63'd0, step_flush}, 64'd1);
        @(negedge clock);
        flush = 1'b0;
        checkOutput("flush_ready_low", {63'd0, ready}, 64'd0);
        checkOutput("flush_step_valid_low", {63'd0, step_valid}, 64'd0);
        applyStimulus("divu_9_3_after_flush", OPB_DIVU, 32'd9, 32'd3, 32'd3, 0);

        // Flush together with valid in IDLE: nothing captured, nothing started
        driveOp(OPB_DIV, 32'h1234, 32'd0);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        clearOp();
        checkOutput("flush_valid_no_ready", {63'd0, ready}, 64'd0);
        checkOutput("flush_valid_no_run", {63'd0, step_valid}, 64'd0);
        checkOutput("flush_valid_no_capture", {32'd0, step_rs1}, 64'd9);
        @(negedge clock);

        // Reset in the middle of RUN discards the operation
        driveOp(OPB_DIVU, 32'd100, 32'd7);
        repeat (6) @(negedge clock);
        reset = 1'b1;
        clearOp();
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midrun_reset_count", {58'd0, count}, 64'd0);
        checkOutput("midrun_reset_acc", acc, 64'd0);
        checkOutput("midrun_reset_arg_0", {32'd0, arg_0}, 64'd0);
        checkOutput("midrun_reset_result", {32'd0, result}, 64'd0);
        checkOutput("midrun_reset_step_rs1", {32'd0, step_rs1}, 64'd0);
        checkOutput("midrun_reset_ready", {63'd0, ready}, 64'd0);
        repeat (40) @(negedge clock);

        applyStimulus("divu_50_5_hold", OPB_DIVU, 32'd50, 32'd5, 32'd10, 3);
        applyStimulus("remu_50_6_next", OPB_REMU, 32'd50, 32'd6, 32'd2,  0);

        repeat (40) @(negedge clock);
        checkOutput("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
